// File: rtl/jtkcpu_brunit.sv
// rtl/jtkcpu_brunit.sv - branch unit: fetches a branch offset, evaluates the condition, produces next PC
module jtkcpu_brunit #(
  parameter int AW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          start,
  input  logic [7:0]    op,
  input  logic [7:0]    cc,
  input  logic          loop,
  input  logic [CW-1:0] cnt,
  input  logic [AW-1:0] pc,
  input  logic [7:0]    din,
  input  logic          din_vld,
  output logic          rd,
  output logic          busy,
  output logic          done,
  output logic          taken,
  output logic [AW-1:0] new_pc,
  output logic          push,
  output logic [AW-1:0] ret_addr,
  output logic [CW-1:0] cnt_out,
  output logic          cnt_we,
  output logic          ill
);

  typedef enum logic [2:0] {IDLE, FETCH_HI, FETCH_LO, CALC, DONE} state_t;

  state_t        st;
  logic [7:0]    op_l;
  logic [3:0]    cc_l;
  logic [AW-1:0] pc_l;
  logic          loop_l;
  logic [CW-1:0] cnt_l;
  logic [7:0]    off_hi, off_lo;

  // only NZVC matter for branches
  logic unused_cc;
  assign unused_cc = ^cc[7:4];

  function automatic logic is_bsr(input logic [7:0] o);
    return (o == 8'hAA) || (o == 8'hAB);
  endfunction

  function automatic logic is_legal(input logic [7:0] o);
    return (o[7:5] == 3'b011) || is_bsr(o);
  endfunction

  function automatic logic is_long(input logic [7:0] o);
    return is_bsr(o) ? o[0] : o[3];
  endfunction

  function automatic logic cond(input logic [7:0] o, input logic [3:0] c);
    logic base;
    case (o[2:0])
      3'd0:    base = 1'b1;
      3'd1:    base = !(c[2] | c[0]);
      3'd2:    base = !c[0];
      3'd3:    base = !c[2];
      3'd4:    base = !c[1];
      3'd5:    base = !c[3];
      3'd6:    base = !(c[3] ^ c[1]);
      default: base = !(c[3] ^ c[1]) & !c[2];
    endcase
    return is_bsr(o) ? 1'b1 : (base ^ o[4]);
  endfunction

  logic               long_c;
  logic [AW-1:0]      pc_next, off_ext, target;
  logic signed [7:0]  off8;
  logic signed [15:0] off16;
  logic [CW-1:0]      cnt_dec;
  logic               taken_c;

  assign long_c  = is_long(op_l);
  assign pc_next = pc_l + (long_c ? AW'(2) : AW'(1));
  assign off8    = off_lo;
  assign off16   = {off_hi, off_lo};
  // signed size casts sign-extend the offset to the PC width
  assign off_ext = long_c ? AW'(off16) : AW'(off8);
  assign target  = pc_next + off_ext;
  assign cnt_dec = cnt_l - CW'(1);
  assign taken_c = loop_l ? (cnt_dec != '0) : cond(op_l, cc_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      op_l     <= '0;
      cc_l     <= '0;
      pc_l     <= '0;
      loop_l   <= 1'b0;
      cnt_l    <= '0;
      off_hi   <= '0;
      off_lo   <= '0;
      rd       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      taken    <= 1'b0;
      new_pc   <= '0;
      push     <= 1'b0;
      ret_addr <= '0;
      cnt_out  <= '0;
      cnt_we   <= 1'b0;
      ill      <= 1'b0;
    end else if (cen) begin
      case (st)
        IDLE: begin
          if (start) begin
            op_l   <= op;
            cc_l   <= cc[3:0];
            pc_l   <= pc;
            loop_l <= loop;
            cnt_l  <= cnt;
            off_hi <= '0;
            off_lo <= '0;
            busy   <= 1'b1;
            if (!is_legal(op)) begin
              st <= CALC;
            end else begin
              st <= is_long(op) ? FETCH_HI : FETCH_LO;
              rd <= 1'b1;
            end
          end
        end
        FETCH_HI: begin
          if (din_vld) begin
            off_hi <= din;
            st     <= FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (din_vld) begin
            off_lo <= din;
            rd     <= 1'b0;
            st     <= CALC;
          end
        end
        CALC: begin
          st   <= DONE;
          done <= 1'b1;
          if (!is_legal(op_l)) begin
            ill    <= 1'b1;
            taken  <= 1'b0;
            new_pc <= pc_l;
          end else begin
            ill      <= 1'b0;
            taken    <= taken_c;
            new_pc   <= taken_c ? target : pc_next;
            ret_addr <= pc_next;
            push     <= is_bsr(op_l);
            cnt_we   <= loop_l;
            if (loop_l) cnt_out <= cnt_dec;
          end
        end
        DONE: begin
          done   <= 1'b0;
          push   <= 1'b0;
          cnt_we <= 1'b0;
          busy   <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtkcpu_brunit.sv
// tb/tb_jtkcpu_brunit.sv - directed bench for jtkcpu_brunit
module tb_jtkcpu_brunit;
  logic        clk = 1'b0, rst_n = 1'b0, cen = 1'b1, start = 1'b0, loop = 1'b0, din_vld = 1'b0;
  logic [7:0]  op = '0, cc = '0, din = '0, cnt = '0;
  logic [15:0] pc = '0;
  logic        rd, busy, done, taken, push, cnt_we, ill;
  logic [15:0] new_pc, ret_addr;
  logic [7:0]  cnt_out;

  int n_cmp = 0, n_bad = 0;
  int lat;
  bit saw_rd;

  jtkcpu_brunit #(.AW(16), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start(start), .op(op), .cc(cc),
    .loop(loop), .cnt(cnt), .pc(pc), .din(din), .din_vld(din_vld),
    .rd(rd), .busy(busy), .done(done), .taken(taken), .new_pc(new_pc),
    .push(push), .ret_addr(ret_addr), .cnt_out(cnt_out), .cnt_we(cnt_we), .ill(ill)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issues one branch, serves offset bytes on rd, optional stall before the second byte
  task automatic run_br(input logic [7:0] o, input logic [7:0] c, input logic [15:0] p,
                        input logic l, input logic [7:0] n, input logic [7:0] b0,
                        input logic [7:0] b1, input int stall);
    int k, st, g;
    g = 0;
    while (busy && g < 10) begin
      @(posedge clk); #1; g++;
    end
    op = o; cc = c; pc = p; loop = l; cnt = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; k = 0; st = 0; saw_rd = 1'b0;
    while (!done && lat < 60) begin
      if (rd) begin
        saw_rd = 1'b1;
        if (k == 1 && st < stall) begin
          din_vld = 1'b0; st++;
        end else begin
          din = (k == 0) ? b0 : b1; din_vld = 1'b1; k++;
        end
      end else begin
        din_vld = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    din_vld = 1'b0;
    if (!done) check("timeout", 0, 1);
  endtask

  function automatic logic exp_cond(input logic [7:0] o, input logic [3:0] f);
    logic cf, v, z, n, r;
    cf = f[0]; v = f[1]; z = f[2]; n = f[3];
    case (o[2:0])
      3'd0: r = 1'b1;
      3'd1: r = !(z || cf);
      3'd2: r = !cf;
      3'd3: r = !z;
      3'd4: r = !v;
      3'd5: r = !n;
      3'd6: r = (n == v);
      default: r = (n == v) && !z;
    endcase
    return o[4] ? !r : r;
  endfunction

  initial begin
    #1;
    check("reset_busy", busy, 0);
    check("reset_flags", {done, taken, push, cnt_we, ill, rd}, 0);
    check("reset_pc", new_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    cen = 1'b0; op = 8'h60; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cen_hold_busy", busy, 0);
    start = 1'b0; cen = 1'b1;

    run_br(8'h12, 8'h00, 16'h4567, 1'b1, 8'h05, 8'h00, 8'h00, 0);
    check("ill_flag", ill, 1);
    check("ill_taken", taken, 0);
    check("ill_pc", new_pc, 16'h4567);
    check("ill_push_we", {push, cnt_we}, 0);
    check("ill_latency", lat, 2);
    check("ill_no_rd", saw_rd, 0);

    run_br(8'h73, 8'h04, 16'h1000, 1'b0, 8'h00, 8'hFE, 8'h00, 0);
    check("beq_taken", taken, 1);
    check("beq_pc", new_pc, 16'h0FFF);
    check("beq_latency", lat, 3);
    check("beq_ill", ill, 0);
    check("beq_push", push, 0);

    run_br(8'h6B, 8'h04, 16'hFFFE, 1'b0, 8'h00, 8'h00, 8'h10, 0);
    check("lbne_taken", taken, 0);
    check("lbne_pc", new_pc, 16'h0000);
    check("lbne_latency", lat, 4);

    run_br(8'hAB, 8'h00, 16'h2000, 1'b0, 8'h00, 8'h7F, 8'hFF, 5);
    check("lbsr_push", push, 1);
    check("lbsr_ret", ret_addr, 16'h2002);
    check("lbsr_pc", new_pc, 16'hA001);
    check("lbsr_latency", lat, 9);
    @(posedge clk); #1;
    check("post_done", {done, push, cnt_we, busy}, 0);
    check("post_hold_pc", new_pc, 16'hA001);

    run_br(8'hAA, 8'h0F, 16'h5000, 1'b0, 8'h00, 8'h80, 8'h00, 0);
    check("bsr_pc", new_pc, 16'h4F81);
    check("bsr_ret", ret_addr, 16'h5001);
    check("bsr_push_taken", {push, taken}, 2'b11);

    run_br(8'h60, 8'h00, 16'h1000, 1'b1, 8'h01, 8'h20, 8'h00, 0);
    check("loop1_cnt", cnt_out, 8'h00);
    check("loop1_taken", taken, 0);
    check("loop1_we", cnt_we, 1);
    check("loop1_pc", new_pc, 16'h1001);
    run_br(8'h60, 8'h00, 16'h1000, 1'b1, 8'h00, 8'h20, 8'h00, 0);
    check("loop0_cnt", cnt_out, 8'hFF);
    check("loop0_taken", taken, 1);
    check("loop0_pc", new_pc, 16'h1021);
    run_br(8'h70, 8'h00, 16'h1000, 1'b1, 8'h03, 8'h20, 8'h00, 0);
    check("loop_cc_ignored", {taken, cnt_out}, {1'b1, 8'h02});

    for (int o = 8'h60; o <= 8'h7F; o++) begin
      for (int c = 0; c < 16; c++) begin
        run_br(o[7:0], {4'h0, c[3:0]}, 16'h0100, 1'b0, 8'h00, 8'h00, 8'h00, 0);
        check($sformatf("sweep_op%02x_cc%x", o, c), taken, exp_cond(o[7:0], c[3:0]));
      end
    end

    @(posedge clk); #1;
    @(posedge clk); #1;
    op = 8'h68; cc = 8'h00; pc = 16'h7000; loop = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; din = 8'h12; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    check("mid_fetch_rd", rd, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_outs", {rd, done, taken, ill}, 0);
    check("rst_pc", new_pc, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    run_br(8'h60, 8'h00, 16'h3000, 1'b0, 8'h00, 8'h10, 8'h00, 0);
    check("bra_after_rst_pc", new_pc, 16'h3011);
    check("bra_after_rst_lat", lat, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
